// File: rtl/retire_trace_buffer_pkg.sv
// Shared types for the retirement trace path: record layout and its packed width.
// Every file that formats or carries a trace record imports this package.
package core_trace_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
  } trace_t;

  localparam int TRACE_W = $bits(trace_t);

  // x0 writes are architecturally discarded, so the trace reports them as zero.
  function automatic trace_t make_record(input logic [XLEN-1:0] pc,
                                         input logic [XLEN-1:0] instr,
                                         input logic [4:0]      rd,
                                         input logic [XLEN-1:0] data);
    trace_t r;
    r.pc    = pc;
    r.instr = instr;
    r.rd    = rd;
    r.wdata = (rd == 5'd0) ? '0 : data;
    return r;
  endfunction

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Retirement input bundle plus the trace output stream of the trace buffer.
// The master side is the core/consumer pair; the slave side is the buffer itself.
interface retire_trace_if;
  import core_trace_pkg::*;

  logic            update_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] instr_i;
  logic [4:0]      reg_addr_i;
  logic [XLEN-1:0] reg_data_i;

  // trace_o is meaningful only while trace_valid_o=1 and then stays stable until
  // the edge where trace_valid_o && trace_ready_i transfers it; ready may be
  // driven at any time and is ignored while valid is low.
  logic            trace_valid_o;
  logic            trace_ready_i;
  trace_t          trace_o;

  modport master (
    output update_i, pc_i, instr_i, reg_addr_i, reg_data_i, trace_ready_i,
    input  trace_valid_o, trace_o
  );

  modport slave (
    input  update_i, pc_i, instr_i, reg_addr_i, reg_data_i, trace_ready_i,
    output trace_valid_o, trace_o
  );

endinterface

// File: rtl/retire_trace_buffer_fifo.sv
// Generic first-word-fall-through FIFO with wrap-bit pointers and a sync clear.
// Pushes while full are ignored unless a pop frees the slot on the same edge.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures one record per retired instruction into a FWFT FIFO and streams it out,
// keeping a 64-bit retire count, a saturating drop count and a sticky overflow flag.
module retire_trace_buffer
  import core_trace_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clear_i,
  retire_trace_if.slave           rt,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [63:0]             instret_o,
  output logic [DROP_W-1:0]       drop_cnt_o,
  output logic                    overflow_o
);

  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  trace_t             rec_w;
  logic [TRACE_W-1:0] head_w;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop_w;
  logic               drop_w;

  logic [63:0]        instret_q, instret_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic               overflow_q, overflow_d;

  assign rec_w = make_record(rt.pc_i, rt.instr_i, rt.reg_addr_i, rt.reg_data_i);

  assign pop_w  = rt.trace_valid_o && rt.trace_ready_i;
  assign drop_w = rt.update_i && !clear_i && fifo_full && !pop_w;

  trace_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear_i (clear_i),
    .push_i  (rt.update_i),
    .wdata_i (rec_w),
    .pop_i   (rt.trace_ready_i),
    .rdata_o (head_w),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  // The head is masked while empty so the bus reads zero out of reset and after a flush.
  assign rt.trace_valid_o = !fifo_empty;
  assign rt.trace_o       = fifo_empty ? '0 : trace_t'(head_w);

  always_comb begin
    instret_d  = instret_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      instret_d  = '0;
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      instret_d = instret_q + 64'(rt.update_i);
      if (drop_w) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + DROP_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      instret_q  <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      instret_q  <= instret_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign instret_o  = instret_q;
  assign drop_cnt_o = drop_cnt_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations and a randomized traffic phase.
module tb_retire_trace_buffer;
  import core_trace_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DMAX   = (1 << DROP_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  logic [CNT_W-1:0]  count;
  logic [63:0]       instret;
  logic [DROP_W-1:0] drop_cnt;
  logic              overflow;

  retire_trace_if u_if();

  retire_trace_buffer #(
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .clear_i    (clear),
    .rt         (u_if),
    .count_o    (count),
    .instret_o  (instret),
    .drop_cnt_o (drop_cnt),
    .overflow_o (overflow)
  );

  // ---------------- reference model ----------------
  logic [TRACE_W-1:0] exp_q[$];
  logic [63:0]        m_instret = '0;
  int                 m_drop = 0;
  bit                 m_ovf = 1'b0;

  int tests = 0;
  int fails = 0;

  function automatic logic [TRACE_W-1:0] rec_of(input logic [31:0] pc, input logic [31:0] instr,
                                                input logic [4:0] rd, input logic [31:0] data);
    logic [31:0] w;
    w = (rd == 5'd0) ? 32'h0 : data;
    return {pc, instr, rd, w};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_instret = '0;
    m_drop    = 0;
    m_ovf     = 1'b0;
  endtask

  // Called at each rising edge with the inputs that were held across it.
  task automatic model_step();
    if (!rstn || clear) begin
      model_reset();
    end else begin
      if (exp_q.size() > 0 && u_if.trace_ready_i) void'(exp_q.pop_front());
      if (u_if.update_i) begin
        m_instret = m_instret + 64'd1;
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(rec_of(u_if.pc_i, u_if.instr_i, u_if.reg_addr_i, u_if.reg_data_i));
        end else begin
          m_ovf = 1'b1;
          if (m_drop < DMAX) m_drop++;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_valid",    u_if.trace_valid_o, exp_q.size() > 0);
    chk("cmp_trace",    u_if.trace_o, (exp_q.size() > 0) ? exp_q[0] : '0);
    chk("cmp_count",    count, exp_q.size());
    chk("cmp_instret",  instret, m_instret);
    chk("cmp_drop",     drop_cnt, m_drop);
    chk("cmp_overflow", overflow, m_ovf);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
    u_if.update_i   = 1'b1;
    u_if.pc_i       = pc;
    u_if.instr_i    = pc ^ 32'h0000_0013;
    u_if.reg_addr_i = rd;
    u_if.reg_data_i = data;
  endtask

  task automatic idle();
    u_if.update_i = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  logic [TRACE_W-1:0] lit;

  // ---------------- stimulus ----------------
  initial begin
    u_if.update_i = 1'b0; u_if.pc_i = '0; u_if.instr_i = '0;
    u_if.reg_addr_i = '0; u_if.reg_data_i = '0; u_if.trace_ready_i = 1'b0;
    model_reset();
    repeat (2) cyc();
    rstn = 1'b1;
    chk("rst_valid", u_if.trace_valid_o, 0);
    chk("rst_count", count, 0);
    chk("rst_instret", instret, 0);
    chk("rst_trace", u_if.trace_o, 0);

    // three retirements streaming straight through
    u_if.trace_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(32'(i * 4), 5'(i + 1), 32'h1000 + 32'(i));
      cyc();
      chk("t1_valid", u_if.trace_valid_o, 1);
      chk("t1_pc", u_if.trace_o.pc, i * 4);
    end
    idle();
    cyc();
    chk("t1_count", count, 0);
    chk("t1_instret", instret, 3);

    // x0 write is reported as zero
    u_if.trace_ready_i = 1'b0;
    push(32'h40, 5'd0, 32'hDEAD_BEEF);
    cyc();
    idle();
    chk("t2_wdata", u_if.trace_o.wdata, 32'h0);
    chk("t2_rd", u_if.trace_o.rd, 0);
    u_if.trace_ready_i = 1'b1;
    cyc();
    chk("t2_count", count, 0);

    // overflow: DEPTH+2 pushes with no consumer
    do_clear();
    u_if.trace_ready_i = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push(32'h100 + 32'(4 * i), 5'd3, 32'(i));
      cyc();
    end
    idle();
    chk("t3_count", count, DEPTH);
    chk("t3_drop", drop_cnt, 2);
    chk("t3_ovf", overflow, 1);
    chk("t3_instret", instret, DEPTH + 2);
    u_if.trace_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_drain_pc", u_if.trace_o.pc, 32'h100 + 32'(4 * i));
      cyc();
    end
    chk("t3_empty", u_if.trace_valid_o, 0);

    // full with simultaneous push and pop
    do_clear();
    u_if.trace_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push(32'h200 + 32'(4 * i), 5'd4, 32'(i));
      cyc();
    end
    push(32'h300, 5'd5, 32'h55);
    u_if.trace_ready_i = 1'b1;
    cyc();
    idle();
    chk("t4_count", count, DEPTH);
    chk("t4_drop", drop_cnt, 0);
    chk("t4_ovf", overflow, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t4_drain_pc", u_if.trace_o.pc, (i < DEPTH - 1) ? 32'h204 + 32'(4 * i) : 32'h300);
      cyc();
    end

    // backpressure holds the head record
    u_if.trace_ready_i = 1'b0;
    push(32'h500, 5'd7, 32'h1234);
    cyc();
    idle();
    lit = {32'h500, 32'h500 ^ 32'h13, 5'd7, 32'h1234};
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t5_hold", u_if.trace_o, lit);
    end
    u_if.trace_ready_i = 1'b1;
    cyc();
    chk("t5_popped", count, 0);

    // clear together with a push, count=4 and overflow set
    u_if.trace_ready_i = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push(32'h600 + 32'(4 * i), 5'd2, 32'(i));
      cyc();
    end
    idle();
    u_if.trace_ready_i = 1'b1;
    repeat (DEPTH - 4) cyc();
    u_if.trace_ready_i = 1'b0;
    chk("t6_count4", count, 4);
    chk("t6_ovf_set", overflow, 1);
    push(32'h700, 5'd1, 32'h77);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    idle();
    chk("t6_count", count, 0);
    chk("t6_instret", instret, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_valid", u_if.trace_valid_o, 0);

    // drop counter saturation
    for (int i = 0; i < DEPTH + DMAX + 5; i++) begin
      push(32'h800 + 32'(4 * i), 5'd6, 32'(i));
      cyc();
    end
    idle();
    chk("t7_drop_sat", drop_cnt, DMAX);
    chk("t7_ovf", overflow, 1);
    do_clear();

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      u_if.update_i      = ($urandom_range(0, 99) < 60);
      u_if.pc_i          = $urandom;
      u_if.instr_i       = $urandom;
      u_if.reg_addr_i    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      u_if.reg_data_i    = $urandom;
      u_if.trace_ready_i = ($urandom_range(0, 99) < 45);
      clear              = ($urandom_range(0, 63) == 0);
      cyc();
    end
    clear = 1'b0;
    idle();

    // asynchronous reset mid-burst
    do_clear();
    u_if.trace_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(32'h900 + 32'(4 * i), 5'd9, 32'(i));
      cyc();
    end
    chk("t9_pre_count", count, 3);
    #3;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("t9_valid", u_if.trace_valid_o, 0);
    chk("t9_count", count, 0);
    chk("t9_instret", instret, 0);
    chk("t9_trace", u_if.trace_o, 0);
    chk("t9_drop", drop_cnt, 0);
    chk("t9_ovf", overflow, 0);
    cyc();
    rstn = 1'b1;
    idle();
    cyc();
    u_if.trace_ready_i = 1'b1;
    push(32'hA00, 5'd8, 32'h88);
    cyc();
    idle();
    chk("t9_recover_pc", u_if.trace_o.pc, 32'hA00);
    cyc();
    chk("t9_recover_cnt", count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
